// File: rtl/lock_gate.sv
// Gates debounced button pulses while the keypad is locked and drives the lock LED
// (ack blink on toggle, reject flash on dropped press). Define LOCK_GATE_REJ_EN to build REJ/rej_cnt.
module lock_gate #(
  parameter int NBTN       = 4,
  parameter int BLINK_CMAX = 12_500_000,  // 250 ms at 50 MHz
  parameter int ACK_BLINKS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lock,
  input  logic            tr_lock,
  input  logic [NBTN-1:0] pe_btn,
  output logic [NBTN-1:0] pe_btn_q,
  output logic            led_lck,
  output logic            busy,
  output logic [7:0]      rej_cnt
);

  localparam int PW = $clog2(BLINK_CMAX);
  localparam logic [PW-1:0] PH_END = PW'(BLINK_CMAX - 1);
  localparam logic [PW-1:0] PH_ONE = PW'(1);
  localparam logic [3:0]    BL_END = 4'(ACK_BLINKS - 1);

  typedef enum logic [1:0] {IDLE, ACK_ON, ACK_OFF, REJ} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_phase;
  logic [3:0]      r_blink;
  logic [NBTN-1:0] r_q;
  logic            r_led;
  logic            w_led_nxt;
  logic            w_lock_eff;
  logic            w_phase_end;
  logic            w_rej_go;

  // A press in the toggle cycle is judged against the lock level about to take effect.
  assign w_lock_eff  = tr_lock ? ~lock : lock;
  assign w_phase_end = (r_phase == PH_END);

`ifdef LOCK_GATE_REJ_EN
  logic       w_press;
  logic [7:0] r_rej_cnt;

  assign w_press  = |pe_btn;
  assign w_rej_go = w_lock_eff & w_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rej_cnt <= 8'd0;
    end else if (tr_lock && lock) begin
      r_rej_cnt <= 8'd0;
    end else if (w_rej_go && (r_rej_cnt != 8'hFF)) begin
      r_rej_cnt <= r_rej_cnt + 8'd1;
    end
  end

  assign rej_cnt = r_rej_cnt;
`else
  assign w_rej_go = 1'b0;
  assign rej_cnt  = 8'd0;
`endif

  always_comb begin
    w_next = r_state;
    if (tr_lock) begin
      w_next = ACK_ON;
    end else begin
      case (r_state)
        IDLE:    if (w_rej_go) w_next = REJ;
        ACK_ON:  if (w_phase_end) w_next = ACK_OFF;
        ACK_OFF: if (w_phase_end) w_next = (r_blink == BL_END) ? IDLE : ACK_ON;
        REJ:     if (w_phase_end) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // LED is registered from the state being entered so it lines up with busy.
  always_comb begin
    w_led_nxt = 1'b0;
    case (w_next)
      IDLE:    w_led_nxt = w_lock_eff;
      ACK_ON:  w_led_nxt = 1'b1;
      ACK_OFF: w_led_nxt = 1'b0;
      REJ:     w_led_nxt = ~lock;
      default: w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_blink <= 4'd0;
      r_q     <= '0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_q     <= w_lock_eff ? '0 : pe_btn;
      r_led   <= w_led_nxt;
      if (tr_lock || (r_state == IDLE) || w_phase_end) r_phase <= '0;
      else                                             r_phase <= r_phase + PH_ONE;
      if (tr_lock)
        r_blink <= 4'd0;
      else if ((r_state == ACK_OFF) && w_phase_end && (r_blink != BL_END))
        r_blink <= r_blink + 4'd1;
    end
  end

  assign pe_btn_q = r_q;
  assign led_lck  = r_led;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_lock_gate.sv
// Randomized plus directed bench for lock_gate against a timer-based behavioural model.
module tb_lock_gate;
  localparam int C  = 4;
  localparam int AB = 2;
`ifdef LOCK_GATE_REJ_EN
  localparam bit REJ_EN = 1'b1;
`else
  localparam bit REJ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, lock, tr_lock;
  logic [3:0] pe_btn, pe_btn_q;
  logic       led_lck, busy;
  logic [7:0] rej_cnt;

  lock_gate #(.NBTN(4), .BLINK_CMAX(C), .ACK_BLINKS(AB)) dut (
    .clk(clk), .rst(rst), .lock(lock), .tr_lock(tr_lock), .pe_btn(pe_btn),
    .pe_btn_q(pe_btn_q), .led_lck(led_lck), .busy(busy), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an ack is a timer running over 2*C*AB cycles, a reject flash a timer over C cycles.
  logic [3:0] m_q;
  bit         m_led, eff;
  int         m_cnt, ack_t, rej_t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = 4'd0; m_led = 1'b0; m_cnt = 0; ack_t = -1; rej_t = -1;
    end else begin
      eff = tr_lock ? !lock : lock;
      m_q = eff ? 4'd0 : pe_btn;
      if (REJ_EN) begin
        if (tr_lock && lock) m_cnt = 0;
        else if (eff && pe_btn != 4'd0 && m_cnt < 255) m_cnt = m_cnt + 1;
      end
      if (tr_lock) begin
        ack_t = 0; rej_t = -1;
      end else if (ack_t >= 0) begin
        ack_t = ack_t + 1;
        if (ack_t == 2 * C * AB) ack_t = -1;
      end else if (rej_t >= 0) begin
        rej_t = rej_t + 1;
        if (rej_t == C) rej_t = -1;
      end else if (REJ_EN && eff && pe_btn != 4'd0) begin
        rej_t = 0;
      end
      if (ack_t >= 0)      m_led = ((ack_t / C) % 2) == 0;
      else if (rej_t >= 0) m_led = !lock;
      else                 m_led = eff;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("q", pe_btn_q, m_q);
      check("led", led_lck, m_led);
      check("busy", busy, (ack_t >= 0) || (rej_t >= 0));
      check("rej_cnt", rej_cnt, m_cnt);
    end
  end

  // The bench plays the protector: lock inverts on the edge after a tr_lock pulse.
  task automatic step(input bit t, input logic [3:0] p);
    tr_lock = t; pe_btn = p;
    @(posedge clk); #1;
    if (t) lock = !lock;
    tr_lock = 1'b0; pe_btn = 4'd0;
  endtask

  logic [15:0] s;
  logic [4:0]  r;
  logic [3:0]  l4;
  int          nb;
  bit          t;
  logic [3:0]  p;

  initial begin
    rst = 1'b1; lock = 1'b0; tr_lock = 1'b0; pe_btn = 4'd0;
    repeat (2) @(posedge clk); #1;
    check("rst_q", pe_btn_q, 4'd0);
    check("rst_led", led_lck, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rej", rej_cnt, 8'd0);
    rst = 1'b0; chk_en = 1'b1;

    step(0, 4'b0101);
    check("t1_q", pe_btn_q, 4'b0101);
    check("t1_led", led_lck, 1'b0);
    check("t1_busy", busy, 1'b0);
    step(0, 4'b0000);
    check("t1_q_after", pe_btn_q, 4'b0000);

    step(1, 4'b0000);
    s[15] = led_lck; nb = busy;
    for (int i = 1; i < 16; i++) begin
      step(0, 4'b0000); s[15-i] = led_lck; nb += busy;
    end
    check("t2_led_seq", s, 16'hF0F0);
    check("t2_busy_cnt", nb, 16);
    step(0, 4'b0000);
    check("t2_busy_end", busy, 1'b0);
    check("t2_led_hold", led_lck, 1'b1);

    step(0, 4'b0011);
    check("t3_q", pe_btn_q, 4'b0000);
    check("t3_rej", rej_cnt, REJ_EN ? 8'd1 : 8'd0);
    r[4] = led_lck;
    for (int i = 1; i < 5; i++) begin
      step(0, 4'b0000); r[4-i] = led_lck;
    end
    check("t3_led_seq", r, REJ_EN ? 5'b00001 : 5'b11111);

    step(1, 4'b0001);
    check("t4_q", pe_btn_q, 4'b0001);
    check("t4_rej_clr", rej_cnt, 8'd0);
    check("t4_busy", busy, 1'b1);
    check("t4_led", led_lck, 1'b1);
    nb = 1;
    for (int i = 1; i <= 30; i++) begin
      step(i == 6, 4'b0000);
      nb += busy;
      if (i >= 6 && i <= 9) l4[9-i] = led_lck;
    end
    check("t5_led_restart", l4, 4'hF);
    check("t5_busy_cnt", nb, 22);
    check("t5_led_idle", led_lck, 1'b1);

    for (int i = 0; i < 300; i++) step(0, 4'($urandom_range(1, 15)));
    check("t6_sat", rej_cnt, REJ_EN ? 8'd255 : 8'd0);
    for (int i = 0; i < 20 && busy; i++) step(0, 4'b0000);
    check("t6_idle", busy, 1'b0);
    step(0, 4'b1000);
    check("t6_rej_busy", busy, REJ_EN);
    check("t6_rej_led", led_lck, !REJ_EN);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_q", pe_btn_q, 4'd0);
    check("t6_rst_led", led_lck, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rej", rej_cnt, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        step(t, p);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lock_gate.md
Name: lock_gate

Overview:
- Downstream consumer of the keypad-lock protector. Takes its lock level and its one-cycle toggle pulse.
- Gates the debounced button edge pulses so no key press reaches the application while locked.
- Drives the lock LED with an acknowledge blink on every lock/unlock and a reject flash on presses dropped while locked.
- Sits between the per-button debouncers/protector and the application key decoder.

Parameters:
- NBTN, 4, number of gated button pulse lanes (1..16).
- BLINK_CMAX, 250 ms expressed in clk cycles via the team cycle-count macro; length of one LED on or off phase; must be >= 2.
- ACK_BLINKS, 3, on/off pairs emitted after each lock toggle (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- lock  in  1  current lock level from the protector.
- tr_lock  in  1  one-cycle pulse; lock inverts on the following clk edge.
- pe_btn  in  NBTN  one-cycle positive-edge pulses from the button debouncers.
- pe_btn_q  out  NBTN  gated pulses to the application; registered.
- led_lck  out  1  lock indicator LED, registered.
- busy  out  1  high while an ack or reject sequence runs.
- rej_cnt  out  8  saturating count of presses dropped while locked.

Behaviour:
- Reset (async, rst=1): pe_btn_q=0, led_lck=0, busy=0, rej_cnt=0, state IDLE, phase counter=0, blink counter=0.
- Effective lock: lock_eff = tr_lock ? !lock : lock. A press in the toggle cycle is judged against the new state.
- Gating, latency 1 cycle: pe_btn_q <= lock_eff ? 0 : pe_btn. All lanes are independent. Simultaneous pulses pass unchanged.
- Phase counter counts 0..BLINK_CMAX-1 and is cleared on every state entry. A phase ends at count BLINK_CMAX-1.
- State IDLE: led_lck <= lock_eff; busy=0.
  - tr_lock -> ACK_ON, blink count=0.
  - Else, if lock_eff and any pe_btn bit set -> REJ.
- State ACK_ON: led_lck=1.
  - Phase end -> ACK_OFF.
- State ACK_OFF: led_lck=0.
  - Phase end with blink count=ACK_BLINKS-1 -> IDLE.
  - Otherwise increment blink count and go to ACK_ON.
- State REJ: led_lck=!lock for one phase, then IDLE.
- busy=1 in ACK_ON, ACK_OFF and REJ.
- tr_lock in any state, including mid-ACK and REJ, restarts ACK_ON with the phase and blink counters cleared. tr_lock has priority over a reject in the same cycle.
- Presses dropped while busy do not start a new REJ and are not queued. They still increment rej_cnt.
- rej_cnt: +1 per cycle in which lock_eff=1 and pe_btn is nonzero; several lanes in one cycle count as 1.
  - Saturates at 255.
  - Clears to 0 in the cycle tr_lock arrives with lock=1 (unlock). This clear has priority over an increment.
- Reset mid-sequence aborts immediately to the reset values.
- Counter widths: $clog2(BLINK_CMAX) for the phase counter, 4 bits for the blink counter. No wrap is reachable within the legal ranges.

Optional Feature:
- Macro: LOCK_GATE_REJ_EN.
- Defined: REJ state and rej_cnt are implemented as described above.
- Undefined: REJ state is removed and presses while locked are silently dropped. rej_cnt is tied to 0; ACK and gating are unchanged.

Test Plan:
- All tests use NBTN=4, BLINK_CMAX=4, ACK_BLINKS=2.
- Unlocked, pe_btn=4'b0101 for one cycle -> pe_btn_q=4'b0101 exactly one cycle later; led_lck=0; busy=0.
- tr_lock with lock=0 -> led_lck sequence 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0 then holds 1; busy high for exactly 16 cycles.
- Locked, idle, pe_btn=4'b0011 -> pe_btn_q stays 0; led_lck 0 for 4 cycles then 1; rej_cnt=1.
- pe_btn=4'b0001 in the same cycle as tr_lock with lock=1 -> pe_btn_q=4'b0001 next cycle; rej_cnt cleared to 0; ACK starts.
- Second tr_lock 6 cycles into an ACK -> blink restarts; led_lck=1 for 4 cycles; total busy is 6+16 cycles.
- 300 rejected presses while locked -> rej_cnt=255; assert rst mid-REJ -> all outputs 0 the same cycle. Rerun with LOCK_GATE_REJ_EN undefined -> no REJ flash and rej_cnt stays 0.
